fifo_wr_arbiter: RTL and testbench



---
 rtl/fifo_wr_arbiter_if.sv | 32 +++
 rtl/fifo_wr_arbiter.sv | 144 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: bundles producer handshakes and the FIFO write port around fifo_wr_arbiter.
// Latency: none, wires only. Backpressure: req_ready carries the grant, the FIFO flags carry space.
// Ports: master = arbiter side (drives req_ready, fifo_wr_en, fifo_data_in, grant_id, ack_err);
//        slave  = producers + FIFO side (drives req_valid, req_data and the FIFO status flags).
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 16
);
  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_full;
  logic                          fifo_almostfull;
  logic                          fifo_wr_ack;
  logic                          fifo_overflow;
  logic                          fifo_wr_en;
  logic [FIFO_WIDTH-1:0]         fifo_data_in;
  logic [IW-1:0]                 grant_id;
  logic                          ack_err;

  modport master (
    input  req_valid, req_data, fifo_full, fifo_almostfull, fifo_wr_ack, fifo_overflow,
    output req_ready, fifo_wr_en, fifo_data_in, grant_id, ack_err
  );

  modport slave (
    output req_valid, req_data, fifo_full, fifo_almostfull, fifo_wr_ack, fifo_overflow,
    input  req_ready, fifo_wr_en, fifo_data_in, grant_id, ack_err
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port between NUM_REQ producers, bursts up to MAX_BURST.
// Latency: 1 cycle from producer transfer to registered fifo_wr_en/fifo_data_in/grant_id.
// Backpressure: req_ready (combinational, one-hot or zero) drops while the FIFO flags show no room.
// Ports: clk, rst (async, active-high); bus = fifo_wr_arbiter_if.master (producer handshakes + FIFO write port).
// Option: define FIFO_WR_ARB_ACK_CHECK_EN to build the wr_ack/overflow checker behind the sticky ack_err.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int MAX_BURST  = 4
) (
  input logic               clk,
  input logic               rst,
  fifo_wr_arbiter_if.master bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
  localparam logic [IW-1:0] LAST_REQ  = IW'(NUM_REQ - 1);
  localparam logic [0:0]    IDLE      = 1'b0;
  localparam logic [0:0]    BURST     = 1'b1;

  // Depth is informational only; throttling relies purely on the FIFO flags.
  localparam int unused_fifo_depth = FIFO_DEPTH;

  logic [0:0]            state;
  logic [IW-1:0]         owner;
  logic [IW-1:0]         rr_ptr;
  logic [BW-1:0]         burst_cnt;
  logic                  wr_en_q;
  logic [FIFO_WIDTH-1:0] data_q;
  logic [IW-1:0]         grant_id_q;

  logic                  space;
  logic                  keep;
  logic                  leave;
  logic                  gnt_vld;
  logic [IW-1:0]         gnt_idx;
  logic [IW-1:0]         search_ptr;
  logic [IW-1:0]         next_ptr;
  logic [NUM_REQ-1:0]    cand;
  logic [NUM_REQ-1:0]    others;
  logic [FIFO_WIDTH-1:0] words [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
    assign words[g] = bus.req_data[g*FIFO_WIDTH +: FIFO_WIDTH];
  end

  assign next_ptr = (owner == LAST_REQ) ? '0 : owner + IW'(1);
  // Valid requesters other than the current owner; the owner only re-wins when it is alone.
  assign others   = bus.req_valid & ~(NUM_REQ'(1) << owner);

  always_comb begin
    int idx;
    idx        = 0;
    // A write already registered this cycle is counted as occupied; reads are ignored.
    space      = wr_en_q ? !(bus.fifo_full || bus.fifo_almostfull) : !bus.fifo_full;
    keep       = 1'b0;
    leave      = 1'b0;
    search_ptr = rr_ptr;
    cand       = bus.req_valid;
    gnt_vld    = 1'b0;
    gnt_idx    = '0;
    if (state == BURST) begin
      keep  = bus.req_valid[owner] && space && (burst_cnt < BURST_MAX);
      leave = !keep;
      if (!keep) begin
        search_ptr = next_ptr;
        if (others != '0) cand = others;
      end
    end
    if (keep) begin
      gnt_vld = 1'b1;
      gnt_idx = owner;
    end else if (space) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        idx = int'(search_ptr) + i;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (!gnt_vld && cand[IW'(idx)]) begin
          gnt_vld = 1'b1;
          gnt_idx = IW'(idx);
        end
      end
    end
  end

  // Grant is suppressed during reset so req_ready reads zero immediately.
  assign bus.req_ready = (gnt_vld && !rst) ? (NUM_REQ'(1) << gnt_idx) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= '0;
      rr_ptr     <= '0;
      burst_cnt  <= '0;
      wr_en_q    <= 1'b0;
      data_q     <= '0;
      grant_id_q <= '0;
    end else begin
      wr_en_q <= gnt_vld;
      if (leave) rr_ptr <= next_ptr;
      if (gnt_vld) begin
        data_q     <= words[gnt_idx];
        grant_id_q <= gnt_idx;
        if (keep) begin
          burst_cnt <= burst_cnt + BW'(1);
        end else begin
          // Fresh grant from IDLE or re-arbitration on burst exit.
          state     <= BURST;
          owner     <= gnt_idx;
          burst_cnt <= BW'(1);
        end
      end else begin
        state <= IDLE;
      end
    end
  end

  assign bus.fifo_wr_en   = wr_en_q;
  assign bus.fifo_data_in = data_q;
  assign bus.grant_id     = grant_id_q;

`ifdef FIFO_WR_ARB_ACK_CHECK_EN
  logic wr_pend;
  logic ack_err_q;

  // The FIFO answers a write one cycle after fifo_wr_en; wr_pend lines the two up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_pend   <= 1'b0;
      ack_err_q <= 1'b0;
    end else begin
      wr_pend <= wr_en_q;
      if (wr_pend && (!bus.fifo_wr_ack || bus.fifo_overflow)) ack_err_q <= 1'b1;
    end
  end

  assign bus.ack_err = ack_err_q;
`else
  logic unused_ack;
  assign unused_ack  = bus.fifo_wr_ack ^ bus.fifo_overflow;
  assign bus.ack_err = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed bench for fifo_wr_arbiter with a small FIFO flag model behind it.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1-2 units after it.
module tb_fifo_wr_arbiter;
  localparam int NUM_REQ = 4;
  localparam int W       = 16;
  localparam int DEPTH   = 8;
  localparam int MAXB    = 4;
`ifdef FIFO_WR_ARB_ACK_CHECK_EN
  localparam logic ACK_ON = 1'b1;
`else
  localparam logic ACK_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rd = 1'b0;
  logic force_nack = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .FIFO_WIDTH(W)) bus ();

  fifo_wr_arbiter #(
    .NUM_REQ(NUM_REQ), .FIFO_WIDTH(W), .FIFO_DEPTH(DEPTH), .MAX_BURST(MAXB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // FIFO occupancy model: write accepted unless full, optional read drain.
  int   count;
  logic ack_q;
  logic ovf_q;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 0;
      ack_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      ack_q <= bus.fifo_wr_en && (count < DEPTH);
      ovf_q <= bus.fifo_wr_en && (count >= DEPTH);
      count <= count + ((bus.fifo_wr_en && count < DEPTH) ? 1 : 0) - ((rd && count > 0) ? 1 : 0);
    end
  end
  assign bus.fifo_full       = (count == DEPTH);
  assign bus.fifo_almostfull = (count == DEPTH - 1);
  assign bus.fifo_wr_ack     = ack_q && !force_nack;
  assign bus.fifo_overflow   = ovf_q;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_word(input int i, input logic [W-1:0] v);
    bus.req_data[i*W +: W] = v;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    bus.req_valid = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int nwr;
    int ovf;
    logic [31:0] exp_g;
    bus.req_valid = 4'b1111;
    bus.req_data  = '0;

    // Reset state, with requests pending to prove req_ready is gated.
    #2;
    check("rst_wr_en", 32'(bus.fifo_wr_en), 0);
    check("rst_data", 32'(bus.fifo_data_in), 0);
    check("rst_gid", 32'(bus.grant_id), 0);
    check("rst_ack_err", 32'(bus.ack_err), 0);
    check("rst_ready", 32'(bus.req_ready), 0);
    tick();
    tick();

    // Single producer, three words.
    rst = 1'b0;
    bus.req_valid = 4'b0001;
    set_word(0, 16'h00A1);
    #1;
    check("t1_ready", 32'(bus.req_ready), 32'h1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t1_wr_en", 32'(bus.fifo_wr_en), 1);
      check("t1_data", 32'(bus.fifo_data_in), 32'h00A1);
      check("t1_gid", 32'(bus.grant_id), 0);
      check("t1_ack_err", 32'(bus.ack_err), 0);
    end
    bus.req_valid = 4'b0000;
    tick();
    check("t1_idle_wr_en", 32'(bus.fifo_wr_en), 0);
    check("t1_hold_data", 32'(bus.fifo_data_in), 32'h00A1);
    check("t1_rr_ptr", 32'(dut.rr_ptr), 1);

    // All four valid, drained every cycle: bursts of four, wrap to 0.
    reset_pulse();
    rd = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) set_word(i, 16'hB000 | 16'(i << 4));
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 17; k++) begin
      tick();
      exp_g = 32'((k / 4) % 4);
      check("t2_wr_en", 32'(bus.fifo_wr_en), 1);
      check("t2_gid", 32'(bus.grant_id), exp_g);
      check("t2_data", 32'(bus.fifo_data_in), 32'hB000 | (exp_g << 4));
      if (k == 15) check("t2_rr_ptr_3", 32'(dut.rr_ptr), 3);
      if (k == 16) check("t2_rr_ptr_wrap", 32'(dut.rr_ptr), 0);
    end

    // Requesters 1 and 3, no reads: exactly DEPTH writes then stall.
    reset_pulse();
    rd = 1'b0;
    set_word(1, 16'h0C01);
    set_word(3, 16'h0C03);
    bus.req_valid = 4'b1010;
    nwr = 0;
    ovf = 0;
    for (int k = 0; k < 14; k++) begin
      tick();
      if (bus.fifo_overflow) ovf++;
      if (bus.fifo_wr_en) begin
        nwr++;
        check("t3_gid", 32'(bus.grant_id), (nwr <= 4) ? 32'd1 : 32'd3);
        check("t3_data", 32'(bus.fifo_data_in), (nwr <= 4) ? 32'h0C01 : 32'h0C03);
        if (bus.fifo_almostfull) check("t3_af_ready", 32'(bus.req_ready), 0);
      end
    end
    check("t3_writes", 32'(nwr), DEPTH);
    check("t3_overflow", 32'(ovf), 0);
    check("t3_full_ready", 32'(bus.req_ready), 0);
    check("t3_full_wr_en", 32'(bus.fifo_wr_en), 0);
    check("t3_ack_err", 32'(bus.ack_err), 0);

    // Owner 2 leaves after two words while 0 waits.
    reset_pulse();
    rd = 1'b1;
    set_word(0, 16'h0D00);
    set_word(2, 16'h0D02);
    bus.req_valid = 4'b0100;
    tick();
    check("t4_gid_a", 32'(bus.grant_id), 2);
    bus.req_valid = 4'b0101;
    tick();
    check("t4_gid_b", 32'(bus.grant_id), 2);
    check("t4_wr_en_b", 32'(bus.fifo_wr_en), 1);
    bus.req_valid = 4'b0001;
    #1;
    check("t4_ready_move", 32'(bus.req_ready), 32'h1);
    tick();
    check("t4_gid_0", 32'(bus.grant_id), 0);
    check("t4_data_0", 32'(bus.fifo_data_in), 32'h0D00);
    check("t4_rr_ptr", 32'(dut.rr_ptr), 3);

    // Reset in the middle of owner 0's burst clears outputs at once.
    rst = 1'b1;
    #1;
    check("t5_wr_en", 32'(bus.fifo_wr_en), 0);
    check("t5_ready", 32'(bus.req_ready), 0);
    check("t5_ack_err", 32'(bus.ack_err), 0);
    check("t5_gid", 32'(bus.grant_id), 0);
    tick();
    rst = 1'b0;
    bus.req_valid = 4'b0101;
    #1;
    check("t5_first_ready", 32'(bus.req_ready), 32'h1);
    tick();
    check("t5_first_gid", 32'(bus.grant_id), 0);
    check("t5_first_wr_en", 32'(bus.fifo_wr_en), 1);
    check("t5_ack_clean", 32'(bus.ack_err), 0);

    // Missing wr_ack in the cycle after a write.
    tick();
    force_nack = 1'b1;
    tick();
    force_nack = 1'b0;
    check("t6_ack_err_set", 32'(bus.ack_err), 32'(ACK_ON));
    tick();
    tick();
    check("t6_ack_err_sticky", 32'(bus.ack_err), 32'(ACK_ON));
    rst = 1'b1;
    #1;
    check("t6_ack_err_rst", 32'(bus.ack_err), 0);
    tick();
    rst = 1'b0;
    bus.req_valid = '0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
